dpram_be: RTL
=============

# dpram_be

Parametrised true dual-port RAM with per-byte write enables, an optional output pipeline register and a defined cross-port read-during-write mode. After reset it runs a built-in clear engine so every word holds a known value. It serves as the general-purpose on-chip buffer for the compute tiles and replaces the plain two-port RAM wherever partial-word writes, deterministic initial contents or collision reporting are required.

## Interface
- AWIDTH, 10, address width of each port
- NUM_WORDS, 1024, number of words; at most 2**AWIDTH
- DWIDTH, 32, data width; must be a multiple of 8
- BEWIDTH, DWIDTH/8, byte-enable width; derived, do not override
- OUT_REG, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency)
- RDW_MODE, 0, cross-port read of an address written the same cycle: 0 = old data, 1 = new data
- INIT_VALUE, 0, DWIDTH-wide word written to every address by the clear engine

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- init_req  in  1  single-cycle pulse; restarts the clear engine (accepted only when ready=1)
- ready  out  1  high when user accesses are accepted
- address_a / address_b  in  AWIDTH  port address
- wren_a / wren_b  in  1  write request
- byteen_a / byteen_b  in  BEWIDTH  byte lanes to write; bit i covers data[8i+7:8i]
- rden_a / rden_b  in  1  read request
- data_a / data_b  in  DWIDTH  write data
- out_a / out_b  out  DWIDTH  read data; holds its value between reads
- valid_a / valid_b  out  1  one-cycle pulse, aligned with new out_x data
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle

## Operation
- FSM states: RESET (rst high), CLEAR, READY.
- RESET → CLEAR on rst deassertion. CLEAR → READY after the clear engine writes word NUM_WORDS-1. READY → CLEAR when init_req=1.
- CLEAR: a counter starts at 0, writes INIT_VALUE to one address per edge, then increments. ready=0. All user wren/rden are ignored: no write, no valid.
- READY, per port:
  - If wren=1, the write is performed. Only lanes with byteen=1 are updated. No read happens even if rden=1.
  - If rden=1 and wren=0, a read is issued.
- Out-of-range address (≥ NUM_WORDS): the write is dropped. A read returns all zeros and still produces valid.
- Same-address write/write, both ports:
  - Lanes enabled on A take A data.
  - Lanes enabled only on B take B data.
  - collision pulses whenever the addresses match, even if the byte enables do not overlap.
- Same-address write on one port, read on the other:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the post-write word, with the byte merge applied.
- rst asserted at any time:
  - Clear and user operation abort immediately.
  - State returns to RESET.
  - A full clear reruns from address 0 after rst deasserts.
  - Memory contents are undefined until that clear completes.

## Timing
- Reset values: out_a=out_b=0, valid_a=valid_b=0, ready=0, collision=0, clear counter=0.
- Clear duration:
  - Edge 1 after rst deasserts writes address 0; edge NUM_WORDS writes address NUM_WORDS-1.
  - ready is high after edge NUM_WORDS.
- init_req sampled on an edge: ready is low after that edge and stays low for NUM_WORDS edges, then returns high.
- Read latency, request sampled on edge N:
  - OUT_REG=0: out/valid are updated on edge N+1.
  - OUT_REG=1: out/valid are updated on edge N+2. The pipeline is fully pipelined: one read per port per cycle.
- A write sampled on edge N is visible to a same-port read sampled on edge N+1.
- collision is registered: asserted after edge N+1 for writes sampled on edge N.
- Reads already in the OUT_REG pipeline when CLEAR starts still complete with their valid pulse.

## Test plan
- Reset and clear (NUM_WORDS=16, INIT_VALUE=32'hA5A5A5A5): deassert rst → ready rises after exactly 16 edges; reads of addresses 0..15 return A5A5A5A5 with valid one cycle later.
- Byte enables: write 32'h11223344 to addr 3 with byteen=4'b1111, then 32'hFFFFFFFF with byteen=4'b0101 → read of addr 3 returns 32'h11FF33FF.
- Collision: A writes 32'hAAAAAAAA with byteen=4'b0011, B writes 32'hBBBBBBBB with byteen=4'b1111, both to addr 7 in the same cycle → collision pulses one cycle; addr 7 reads 32'hBBBBAAAA.
- Cross-port RDW: addr 5 holds 32'h1; A writes 32'h2 while B reads addr 5 → out_b=1 with RDW_MODE=0, out_b=2 with RDW_MODE=1.
- Latency and out-of-range (OUT_REG=1, NUM_WORDS=12): back-to-back reads of addr 0, 1, 13 → valid_a high on three consecutive cycles starting 2 edges after the first request; third output is 0.
- Reset mid-clear and init_req: assert rst at clear address 8 → ready stays low and the clear restarts at address 0. In READY, write 32'h55 to addr 2, pulse init_req → ready low for NUM_WORDS edges, then addr 2 reads INIT_VALUE.

Source files
------------

// File: rtl/dpram_be.sv
// rtl/dpram_be.sv - true dual-port RAM with byte enables, optional output register and clear engine
// After reset or init_req, every word is written with INIT_VALUE before user access is accepted.
module dpram_be #(
  parameter int                AWIDTH     = 10,
  parameter int                NUM_WORDS  = 1024,
  parameter int                DWIDTH     = 32,
  parameter int                BEWIDTH    = DWIDTH / 8,
  parameter int                OUT_REG    = 0,
  parameter int                RDW_MODE   = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_req,
  output logic               ready,
  input  logic [AWIDTH-1:0]  address_a,
  input  logic               wren_a,
  input  logic [BEWIDTH-1:0] byteen_a,
  input  logic               rden_a,
  input  logic [DWIDTH-1:0]  data_a,
  output logic [DWIDTH-1:0]  out_a,
  output logic               valid_a,
  input  logic [AWIDTH-1:0]  address_b,
  input  logic               wren_b,
  input  logic [BEWIDTH-1:0] byteen_b,
  input  logic               rden_b,
  input  logic [DWIDTH-1:0]  data_b,
  output logic [DWIDTH-1:0]  out_b,
  output logic               valid_b,
  output logic               collision
);

  localparam int            IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

  state_t            state, state_nxt;
  logic              clearing;
  logic [IW-1:0]     clr_cnt;
  logic [DWIDTH-1:0] mem [NUM_WORDS];

  logic              in_a, in_b;
  logic [IW-1:0]     idx_a, idx_b;
  logic              rd_a, rd_b;
  logic [DWIDTH-1:0] rword_a, rword_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET, S_CLEAR: state_nxt = (clr_cnt == LAST) ? S_READY : S_CLEAR;
      S_READY:          if (init_req) state_nxt = S_CLEAR;
      default:          state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    ready    = (state == S_READY);
    clearing = (state != S_READY);
  end

  // The RESET state already clears address 0 on the first edge after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              clr_cnt <= '0;
    else if (clearing && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
    else                                  clr_cnt <= '0;
  end

  always_comb begin
    in_a  = ({1'b0, address_a} < (AWIDTH+1)'(NUM_WORDS));
    in_b  = ({1'b0, address_b} < (AWIDTH+1)'(NUM_WORDS));
    idx_a = address_a[IW-1:0];
    idx_b = address_b[IW-1:0];
    rd_a  = ready && rden_a && !wren_a;
    rd_b  = ready && rden_b && !wren_b;
  end

  // Port A is applied last so its enabled lanes win a same-address collision.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else begin
      if (wren_b && in_b)
        for (int i = 0; i < BEWIDTH; i++)
          if (byteen_b[i]) mem[idx_b][8*i +: 8] <= data_b[8*i +: 8];
      if (wren_a && in_a)
        for (int i = 0; i < BEWIDTH; i++)
          if (byteen_a[i]) mem[idx_a][8*i +: 8] <= data_a[8*i +: 8];
    end
  end

  always_comb begin
    rword_a = '0;
    rword_b = '0;
    if (in_a) begin
      rword_a = mem[idx_a];
      if (RDW_MODE != 0 && wren_b && address_b == address_a)
        for (int i = 0; i < BEWIDTH; i++)
          if (byteen_b[i]) rword_a[8*i +: 8] = data_b[8*i +: 8];
    end
    if (in_b) begin
      rword_b = mem[idx_b];
      if (RDW_MODE != 0 && wren_a && address_a == address_b)
        for (int i = 0; i < BEWIDTH; i++)
          if (byteen_a[i]) rword_b[8*i +: 8] = data_a[8*i +: 8];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DWIDTH-1:0] pipe_a, pipe_b;
      logic              pv_a, pv_b;
      // Stage two is not gated by state so in-flight reads finish during a clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_a  <= '0;
          pipe_b  <= '0;
          pv_a    <= 1'b0;
          pv_b    <= 1'b0;
          out_a   <= '0;
          out_b   <= '0;
          valid_a <= 1'b0;
          valid_b <= 1'b0;
        end else begin
          pv_a    <= rd_a;
          pv_b    <= rd_b;
          if (rd_a) pipe_a <= rword_a;
          if (rd_b) pipe_b <= rword_b;
          valid_a <= pv_a;
          valid_b <= pv_b;
          if (pv_a) out_a <= pipe_a;
          if (pv_b) out_b <= pipe_b;
        end
      end
    end else begin : g_noreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_a   <= '0;
          out_b   <= '0;
          valid_a <= 1'b0;
          valid_b <= 1'b0;
        end else begin
          valid_a <= rd_a;
          valid_b <= rd_b;
          if (rd_a) out_a <= rword_a;
          if (rd_b) out_b <= rword_b;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= ready && wren_a && wren_b && (address_a == address_b);
  end

endmodule
